// File: rtl/cga_tournament_selector.sv
// ---------------------------------------------------------------------------
// cga_tournament_selector
//
// Tournament selection stage for a compact-GA probability-vector population.
// Each tournament draws Samples individuals from the population, offers each
// one to an external fitness evaluator and keeps the candidate with the
// lowest fitness. At the end it writes the winner and an update rate (tax)
// back to the population with a one-cycle we pulse.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous reset, active-high, overrides everything
//   start        in   begin a tournament (ignored unless idle)
//   individual   in   population output, valid the cycle after pop_ce
//   pop_ce       out  population sample enable, one-cycle pulse
//   eval_valid   out  candidate offered to the evaluator
//   eval_data    out  candidate chromosome, stable while eval_valid is high
//   eval_ready   in   evaluator accepts on eval_valid && eval_ready
//   fit_valid    in   fitness result strobe (only honoured while waiting)
//   fit_value    in   fitness of the last accepted candidate
//   winner       out  best candidate of the current/last tournament
//   tax          out  update rate paired with winner
//   we           out  population write, one-cycle pulse
//   busy         out  high whenever a tournament is in progress
//   done         out  one-cycle pulse, coincident with we
//   best_fitness out  fitness of winner
//   generation   out  completed tournaments, wraps at 16 bits
// ---------------------------------------------------------------------------
module cga_tournament_selector #(
  parameter int Width      = 32,
  parameter int TaxWidth   = 2,
  parameter int FitWidth   = 32,
  parameter int Samples    = 4,
  parameter int CountWidth = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [Width-1:0]    individual,
  output logic                pop_ce,
  output logic                eval_valid,
  output logic [Width-1:0]    eval_data,
  input  logic                eval_ready,
  input  logic                fit_valid,
  input  logic [FitWidth-1:0] fit_value,
  output logic [Width-1:0]    winner,
  output logic [TaxWidth-1:0] tax,
  output logic                we,
  output logic                busy,
  output logic                done,
  output logic [FitWidth-1:0] best_fitness,
  output logic [15:0]         generation
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_COMPARE = 3'd5,
    ST_UPDATE  = 3'd6
  } state_t;

  localparam logic [CountWidth-1:0] SAMPLES_C = CountWidth'(Samples);
  localparam logic [CountWidth-1:0] ONE_C     = CountWidth'(1);
  localparam logic [CountWidth-1:0] WINS_MAX  = {CountWidth{1'b1}};
  localparam int                    TAX_MAX_I = (1 << TaxWidth) - 1;

  state_t                state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] wins_q, wins_d;
  logic                  best_valid_q, best_valid_d;
  logic [Width-1:0]      cand_q, cand_d;
  logic [FitWidth-1:0]   fit_q, fit_d;
  logic [Width-1:0]      winner_q, winner_d;
  logic [FitWidth-1:0]   best_q, best_d;
  logic [TaxWidth-1:0]   tax_q, tax_d;
  logic [15:0]           gen_q, gen_d;
  logic                  pop_ce_q, pop_ce_d;
  logic                  eval_valid_q, eval_valid_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  // Next-state and next-output computation for the tournament FSM.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wins_d       = wins_q;
    best_valid_d = best_valid_q;
    cand_d       = cand_q;
    fit_d        = fit_q;
    winner_d     = winner_q;
    best_d       = best_q;
    gen_d        = gen_q;
    eval_valid_d = eval_valid_q;
    pop_ce_d     = 1'b0;
    we_d         = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SAMPLE;
          count_d      = {CountWidth{1'b0}};
          wins_d       = {CountWidth{1'b0}};
          best_valid_d = 1'b0;
          pop_ce_d     = 1'b1;  // registered, so it is high during SAMPLE
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // individual is valid in the cycle after pop_ce
        cand_d       = individual;
        eval_valid_d = 1'b1;
        state_d      = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (eval_ready) begin
          eval_valid_d = 1'b0;
          state_d      = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (fit_valid) begin
          fit_d   = fit_value;
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_COMPARE: begin
        // Strictly-less keeps the incumbent on ties; the tie counts as a loss
        // for the newcomer and so raises the winner's tax.
        if (!best_valid_q || (fit_q < best_q)) begin
          best_d       = fit_q;
          winner_d     = cand_q;
          wins_d       = {CountWidth{1'b0}};
          best_valid_d = 1'b1;
        end else if (wins_q != WINS_MAX) begin
          wins_d = wins_q + ONE_C;
        end else begin
          wins_d = wins_q;
        end
        count_d = count_q + ONE_C;
        if (count_d == SAMPLES_C) begin
          state_d = ST_UPDATE;
          we_d    = 1'b1;
          done_d  = 1'b1;
          gen_d   = gen_q + 16'd1;
        end else begin
          state_d  = ST_SAMPLE;
          pop_ce_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d      = ST_IDLE;
        eval_valid_d = 1'b0;
      end
    endcase

    if (int'(wins_d) > TAX_MAX_I) begin
      tax_d = TaxWidth'(TAX_MAX_I);
    end else begin
      tax_d = TaxWidth'(wins_d);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= {CountWidth{1'b0}};
      wins_q       <= {CountWidth{1'b0}};
      best_valid_q <= 1'b0;
      cand_q       <= {Width{1'b0}};
      fit_q        <= {FitWidth{1'b0}};
      winner_q     <= {Width{1'b0}};
      best_q       <= {FitWidth{1'b0}};
      tax_q        <= {TaxWidth{1'b0}};
      gen_q        <= 16'd0;
      pop_ce_q     <= 1'b0;
      eval_valid_q <= 1'b0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wins_q       <= wins_d;
      best_valid_q <= best_valid_d;
      cand_q       <= cand_d;
      fit_q        <= fit_d;
      winner_q     <= winner_d;
      best_q       <= best_d;
      tax_q        <= tax_d;
      gen_q        <= gen_d;
      pop_ce_q     <= pop_ce_d;
      eval_valid_q <= eval_valid_d;
      we_q         <= we_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign pop_ce       = pop_ce_q;
  assign eval_valid   = eval_valid_q;
  assign eval_data    = cand_q;
  assign winner       = winner_q;
  assign tax          = tax_q;
  assign we           = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign best_fitness = best_q;
  assign generation   = gen_q;

endmodule
